// File: rtl/result_display.sv
// Captures an adder result with its sign/overflow flags, converts the magnitude to BCD
// bit-serially (double dabble) and scans it onto a 4-digit common-anode display.
// Optional leading-zero blanking: define RESULT_DISPLAY_ZERO_BLANK_EN.
module result_display #(
  parameter int WIDTH       = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Load,
  input  logic [WIDTH-1:0] Result,
  input  logic             Sign,
  input  logic             Overflow,
  output logic             Busy,
  output logic [6:0]       Seg,
  output logic [3:0]       An
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] SHOW    = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_O     = 7'b1000000;

  function automatic logic [6:0] seg_code(input logic [3:0] v);
    case (v)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  logic [1:0]       state_q, state_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [10:0]      bcd_q, bcd_d;
  logic             sign_q, sign_d, ovf_q, ovf_d;
  logic [11:0]      buf_bcd_q, buf_bcd_d;
  logic             buf_sign_q, buf_sign_d, buf_ovf_q, buf_ovf_d;
  logic             buf_valid_q, buf_valid_d;
  logic [CW-1:0]    scan_cnt_q, scan_cnt_d;
  logic [1:0]       dig_q, dig_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;

  logic [10:0]      bcd_adj;
  logic [11:0]      bcd_shift;
  logic [WIDTH-1:0] neg_result;
  logic [3:0]       hund, tens, ones;
  logic             blank_h, blank_t;

  // The WIDTH-bit negation of 0x80 is 0x80, which read unsigned is already 128.
  assign neg_result = (~Result) + {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    bcd_adj = bcd_q;
    for (int i = 0; i < 2; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj, mag_q[WIDTH-1]};
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    mag_d       = mag_q;
    bcd_d       = bcd_q;
    sign_d      = sign_q;
    ovf_d       = ovf_q;
    buf_bcd_d   = buf_bcd_q;
    buf_sign_d  = buf_sign_q;
    buf_ovf_d   = buf_ovf_q;
    buf_valid_d = buf_valid_q;
    if (Load) begin
      state_d   = CONVERT;
      bit_cnt_d = BW'(WIDTH);
      mag_d     = Sign ? neg_result : Result;
      bcd_d     = '0;
      sign_d    = Sign;
      ovf_d     = Overflow;
    end else if (state_q == CONVERT) begin
      mag_d     = {mag_q[WIDTH-2:0], 1'b0};
      bcd_d     = bcd_shift[10:0];
      bit_cnt_d = bit_cnt_q - BW'(1);
      // The final shift lands straight in the display buffer, so Busy and the copy coincide.
      if (bit_cnt_q == BW'(1)) begin
        state_d     = SHOW;
        buf_bcd_d   = bcd_shift;
        buf_sign_d  = sign_q;
        buf_ovf_d   = ovf_q;
        buf_valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + CW'(1);
    dig_d      = dig_q;
    if (scan_cnt_q == CW'(REFRESH_DIV - 1)) begin
      scan_cnt_d = '0;
      dig_d      = dig_q + 2'd1;
    end
  end

  always_comb begin
    hund    = buf_bcd_q[11:8];
    tens    = buf_bcd_q[7:4];
    ones    = buf_bcd_q[3:0];
    blank_h = 1'b0;
    blank_t = 1'b0;
`ifdef RESULT_DISPLAY_ZERO_BLANK_EN
    blank_h = (hund == 4'd0);
    blank_t = (hund == 4'd0) && (tens == 4'd0);
`endif
    seg_d = SEG_BLANK;
    if (!buf_valid_q) begin
      seg_d = SEG_BLANK;
    end else if (buf_ovf_q) begin
      case (dig_d)
        2'd0:    seg_d = SEG_F;
        2'd1:    seg_d = SEG_O;
        default: seg_d = SEG_BLANK;
      endcase
    end else begin
      case (dig_d)
        2'd0:    seg_d = seg_code(ones);
        2'd1:    seg_d = blank_t ? SEG_BLANK : seg_code(tens);
        2'd2:    seg_d = blank_h ? SEG_BLANK : seg_code(hund);
        default: seg_d = buf_sign_q ? SEG_DASH : SEG_BLANK;
      endcase
    end
    // Segment data is decoded for the upcoming digit so Seg and An flip on the same edge.
    an_d = ~(4'b0001 << dig_d);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!Rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      mag_q       <= '0;
      bcd_q       <= '0;
      sign_q      <= 1'b0;
      ovf_q       <= 1'b0;
      buf_bcd_q   <= '0;
      buf_sign_q  <= 1'b0;
      buf_ovf_q   <= 1'b0;
      buf_valid_q <= 1'b0;
      scan_cnt_q  <= '0;
      dig_q       <= 2'd0;
      seg_q       <= SEG_BLANK;
      an_q        <= 4'hF;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      mag_q       <= mag_d;
      bcd_q       <= bcd_d;
      sign_q      <= sign_d;
      ovf_q       <= ovf_d;
      buf_bcd_q   <= buf_bcd_d;
      buf_sign_q  <= buf_sign_d;
      buf_ovf_q   <= buf_ovf_d;
      buf_valid_q <= buf_valid_d;
      scan_cnt_q  <= scan_cnt_d;
      dig_q       <= dig_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign Busy = (state_q == CONVERT);
  assign Seg  = seg_q;
  assign An   = an_q;

endmodule

// File: tb/tb_result_display.sv
// Directed self-checking bench for result_display (WIDTH=8, REFRESH_DIV=4).
// Expectations follow RESULT_DISPLAY_ZERO_BLANK_EN when it is defined.
module tb_result_display;

  localparam int WIDTH = 8;
  localparam int DIV   = 4;

  localparam logic [6:0] S_BL = 7'h7F;
  localparam logic [6:0] S_DS = 7'h3F;
  localparam logic [6:0] S_F  = 7'h0E;
  localparam logic [6:0] S_0  = 7'h40;
  localparam logic [6:0] S_1  = 7'h79;
  localparam logic [6:0] S_2  = 7'h24;
  localparam logic [6:0] S_3  = 7'h30;
  localparam logic [6:0] S_4  = 7'h19;
  localparam logic [6:0] S_7  = 7'h78;
  localparam logic [6:0] S_8  = 7'h00;
`ifdef RESULT_DISPLAY_ZERO_BLANK_EN
  localparam logic [6:0] S_Z  = S_BL;
`else
  localparam logic [6:0] S_Z  = S_0;
`endif

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic             Load = 1'b0;
  logic [WIDTH-1:0] Result = '0;
  logic             Sign = 1'b0;
  logic             Overflow = 1'b0;
  logic             Busy;
  logic [6:0]       Seg;
  logic [3:0]       An;

  int checks = 0;
  int errors = 0;

  result_display #(.WIDTH(WIDTH), .REFRESH_DIV(DIV)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Load(Load), .Result(Result), .Sign(Sign),
    .Overflow(Overflow), .Busy(Busy), .Seg(Seg), .An(An)
  );

  always #5 Clk = ~Clk;

  function automatic logic [6:0] code_for(input logic [3:0] an, input logic [27:0] codes);
    case (an)
      4'b1110: code_for = codes[6:0];
      4'b1101: code_for = codes[13:7];
      4'b1011: code_for = codes[20:14];
      4'b0111: code_for = codes[27:21];
      default: code_for = 7'h55;
    endcase
  endfunction

  // Samples Seg per lit digit at falling edges until all four digits have been seen.
  task automatic read_digits(input string name, output logic [27:0] got);
    logic [3:0] seen;
    seen = 4'b0000;
    got  = '1;
    for (int n = 0; n < 40 && seen != 4'b1111; n++) begin
      @(negedge Clk);
      checks++;
      case (An)
        4'b1110: begin got[6:0]   = Seg; seen[0] = 1'b1; end
        4'b1101: begin got[13:7]  = Seg; seen[1] = 1'b1; end
        4'b1011: begin got[20:14] = Seg; seen[2] = 1'b1; end
        4'b0111: begin got[27:21] = Seg; seen[3] = 1'b1; end
        default: begin
          errors++;
          $display("FAIL %s one_hot: An=%b expected exactly one low bit", name, An);
        end
      endcase
    end
    checks++;
    if (seen != 4'b1111) begin
      errors++;
      $display("FAIL %s scan_timeout: digits seen=%b expected 1111", name, seen);
    end
  endtask

  task automatic pulse_load(input logic [WIDTH-1:0] r, input logic s, input logic o);
    @(negedge Clk);
    Result = r; Sign = s; Overflow = o; Load = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Load = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clk);
    checks++;
    if (An !== 4'hF || Seg !== S_BL || Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: An=%h Seg=%h Busy=%b expected F 7f 0", An, Seg, Busy);
    end
    Rst_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      logic [3:0] exp_an;
      @(negedge Clk);
      exp_an = ~(4'b0001 << ((n / DIV) % 4));
      checks++;
      if (An !== exp_an || Seg !== S_BL) begin
        errors++;
        $display("FAIL scan_after_reset[%0d]: An=%b Seg=%h expected %b 7f", n, An, Seg, exp_an);
      end
    end
  endtask

  // Loads one operand set, checks the Busy window, then reads back all four digits.
  task automatic test_value(input string name, input logic [WIDTH-1:0] r, input logic s,
                            input logic o, input logic [27:0] exp_codes);
    logic [27:0] got;
    pulse_load(r, s, o);
    for (int i = 0; i < WIDTH; i++) begin
      checks++;
      if (Busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy_high[%0d]: Busy=%b expected 1", name, i, Busy);
      end
      @(negedge Clk);
    end
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_fall: Busy=%b expected 0", name, Busy);
    end
    read_digits(name, got);
    checks++;
    if (got !== exp_codes) begin
      errors++;
      $display("FAIL %s digits: got %h expected %h", name, got, exp_codes);
    end
  endtask

  task automatic test_back_to_back();
    logic [27:0] prev, got;
    prev = {S_BL, S_BL, S_O_code(), S_F};
    test_value("b2b_setup_ovf", 8'h00, 1'b0, 1'b1, prev);
    pulse_load(8'd173, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (Seg !== code_for(An, prev)) begin
        errors++;
        $display("FAIL b2b_hold_a[%0d]: Seg=%h An=%b expected %h", i, Seg, An, code_for(An, prev));
      end
      if (i == 2) begin
        Result = 8'd42; Load = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Load = 1'b0;
      end else begin
        @(negedge Clk);
      end
    end
    for (int i = 0; i <= WIDTH; i++) begin
      checks++;
      if (Seg !== code_for(An, prev)) begin
        errors++;
        $display("FAIL b2b_hold_b[%0d]: Seg=%h An=%b expected %h", i, Seg, An, code_for(An, prev));
      end
      @(negedge Clk);
    end
    checks++;
    if (Seg !== code_for(An, {S_BL, S_Z, S_4, S_2})) begin
      errors++;
      $display("FAIL b2b_first_new: Seg=%h An=%b expected %h", Seg, An, code_for(An, {S_BL, S_Z, S_4, S_2}));
    end
    read_digits("b2b_42", got);
    checks++;
    if (got !== {S_BL, S_Z, S_4, S_2}) begin
      errors++;
      $display("FAIL b2b_42 digits: got %h expected %h", got, {S_BL, S_Z, S_4, S_2});
    end
  endtask

  function automatic logic [6:0] S_O_code();
    S_O_code = S_0;
  endfunction

  task automatic test_async_reset();
    logic [27:0] got;
    pulse_load(8'd173, 1'b0, 1'b0);
    repeat (2) @(negedge Clk);
    #1 Rst_n = 1'b0;
    #1;
    checks++;
    if (An !== 4'hF || Seg !== S_BL || Busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: An=%h Seg=%h Busy=%b expected F 7f 0", An, Seg, Busy);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    checks++;
    if (An !== 4'b1110) begin
      errors++;
      $display("FAIL async_reset_first_an: An=%b expected 1110", An);
    end
    read_digits("after_reset_blank", got);
    checks++;
    if (got !== {S_BL, S_BL, S_BL, S_BL}) begin
      errors++;
      $display("FAIL after_reset_blank digits: got %h expected %h", got, {S_BL, S_BL, S_BL, S_BL});
    end
  endtask

  initial begin
    test_reset();
    test_value("pos_173",  8'd173, 1'b0, 1'b0, {S_BL, S_1, S_7, S_3});
    test_value("neg_10",   8'hF6,  1'b1, 1'b0, {S_DS, S_Z, S_1, S_0});
    test_value("neg_128",  8'h80,  1'b1, 1'b0, {S_DS, S_1, S_2, S_8});
    test_value("ovf_neg",  8'h37,  1'b1, 1'b1, {S_BL, S_BL, S_0, S_F});
    test_value("zero",     8'h00,  1'b0, 1'b0, {S_BL, S_Z, S_Z, S_0});
    test_value("pos_255",  8'hFF,  1'b0, 1'b0, {S_BL, S_2, 7'h12, 7'h12});
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
